chunk_au: RTL and testbench

CHUNK_AU -- requirements
Module: chunk_au

---
 rtl/chunk_au_pkg.sv | 23 ++
 rtl/chunk_au_if.sv | 31 +++
 rtl/chunk_au_chunk_add.sv | 22 ++
 rtl/chunk_au.sv | 130 +++++++++++++
 tb/tb_chunk_au.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/chunk_au_pkg.sv
// au_pkg: shared definitions for the chunked add/subtract unit.
//   OP_*    : operation encodings carried on the 2-bit sel input
//   au_state_e : FSM state encoding (IDLE / CALC / DONE)
//   FLAG_*  : bit positions of N, Z, C, V inside the 4-bit flags word
package au_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } au_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/chunk_au_if.sv
// chunk_au_if: request/response bundle for chunk_au.
//   Request : in_valid, in_ready, a, b, sel
//   Response: out_valid, out_ready, x, flags
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both 1. A source holds its payload stable while valid is
// high and ready is low; ready never depends combinationally on valid.
//   master : the requester/consumer side (drives operands, out_ready)
//   slave  : the arithmetic unit side (drives in_ready, result)
interface chunk_au_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] x;
    logic [3:0]       flags;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, x, flags
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, x, flags
    );
endinterface

// File: rtl/chunk_au_chunk_add.sv
// chunk_add: combinational CHUNK-bit adder slice.
//   a, b   : CHUNK-bit operands
//   cin    : carry into bit 0
//   sum    : CHUNK-bit sum
//   cout   : carry out of the top bit
//   c_msb  : carry into the top bit (cout ^ c_msb gives signed overflow)
module chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        // A sum bit is a ^ b ^ carry_in, so the carry into the MSB falls out.
        c_msb = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end
endmodule

// File: rtl/chunk_au.sv
// chunk_au: multi-cycle ADD/SUB/ADC/SBC unit that adds CHUNK bits per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : chunk_au_if slave modport (request, response, x, flags)
//   state_dbg  : current FSM state, for observation only
// An accepted request spends WIDTH/CHUNK cycles in CALC, then holds the
// result in DONE until the consumer takes it. The stored carry flag feeds
// ADC/SBC and only changes when a result is produced (or on reset).
import au_pkg::*;

module chunk_au #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    chunk_au_if.slave   bus,
    output au_state_e   state_dbg
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("chunk_au: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    au_state_e        state;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;      // already inverted for SUB/SBC
    logic [WIDTH-1:0] x_r;
    logic [3:0]       flags_r;
    logic             carry;    // running carry between chunks
    logic             cf;       // stored carry flag for ADC/SBC
    logic [CW-1:0]    k;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] sum;
    logic             cout;
    logic             c_msb;
    logic [WIDTH-1:0] x_next;
    logic             last;

    assign a_chunk = a_r[k*CHUNK +: CHUNK];
    assign b_chunk = b_r[k*CHUNK +: CHUNK];
    assign last    = (k == CW'(NCH - 1));

    chunk_add #(.CHUNK(CHUNK)) u_add (
        .a     (a_chunk),
        .b     (b_chunk),
        .cin   (carry),
        .sum   (sum),
        .cout  (cout),
        .c_msb (c_msb)
    );

    // Result as it will look once this cycle's chunk is written; on the
    // last chunk this is the full result the flags are computed from.
    always_comb begin
        x_next = x_r;
        x_next[k*CHUNK +: CHUNK] = sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            x_r         <= '0;
            flags_r     <= '0;
            carry       <= 1'b0;
            cf          <= 1'b0;
            k           <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_r <= bus.a;
                        b_r <= (bus.sel == OP_SUB || bus.sel == OP_SBC) ? ~bus.b : bus.b;
                        case (bus.sel)
                            OP_ADD:  carry <= 1'b0;
                            OP_SUB:  carry <= 1'b1;
                            default: carry <= cf;
                        endcase
                        k          <= '0;
                        in_ready_r <= 1'b0;
                        state      <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    x_r   <= x_next;
                    carry <= cout;
                    k     <= k + 1'b1;
                    if (last) begin
                        flags_r[FLAG_N] <= x_next[WIDTH-1];
                        flags_r[FLAG_Z] <= (x_next == '0);
                        flags_r[FLAG_C] <= cout;
                        flags_r[FLAG_V] <= cout ^ c_msb;
                        cf              <= cout;
                        out_valid_r     <= 1'b1;
                        state           <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.x         = x_r;
    assign bus.flags     = flags_r;
    assign state_dbg     = state;
endmodule

// File: tb/tb_chunk_au.sv
import au_pkg::*;

module tb_chunk_au;
    logic      clk;
    logic      rst_n;
    au_state_e state_dbg;

    chunk_au_if #(.WIDTH(16)) bus ();

    chunk_au #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];  // {x, flags}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor / scoreboard: one pop per handshake
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got x=%h flags=%b with nothing expected",
                         bus.x, bus.flags);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                if ({bus.x, bus.flags} !== e) begin
                    errors++;
                    $display("FAIL result: got x=%h flags=%b expected x=%h flags=%b",
                             bus.x, bus.flags, e[19:4], e[3:0]);
                end
            end
        end
    end

    // driver: issue one op, check latency; optionally stall the consumer
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic [1:0] tsel,
                         input logic [15:0] ex, input logic [3:0] ef, input int stall);
        int cnt;
        cnt = 0;
        while (!bus.in_ready && cnt < 50) begin
            @(posedge clk); #1; cnt++;
        end
        chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
        exp_q.push_back({ex, ef});
        bus.out_ready = (stall == 0);
        bus.in_valid  = 1'b1;
        bus.a         = ta;
        bus.b         = tb_v;
        bus.sel       = tsel;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        cnt = 0;
        while (!bus.out_valid && cnt < 20) begin
            @(posedge clk); #1; cnt++;
        end
        chk("latency", cnt, 32'd4);
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                chk("stall_x", {16'd0, bus.x}, {16'd0, ex});
                chk("stall_flags", {28'd0, bus.flags}, {28'd0, ef});
                chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
                chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
                bus.in_valid = 1'b1;
                bus.a        = 16'h1111;
                bus.b        = 16'h2222;
                bus.sel      = OP_ADD;
                @(posedge clk); #1;
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("post_handoff_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("post_handoff_in_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int bad;
        int cnt;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sel       = OP_ADD;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_x", {16'd0, bus.x}, 32'd0);
        chk("rst_flags", {28'd0, bus.flags}, 32'd0);
        chk("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(16'h1234, 16'h0001, OP_ADD, 16'h1235, 4'b0000, 0);
        do_op(16'h0005, 16'h0005, OP_SUB, 16'h0000, 4'b0110, 0);
        do_op(16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 4'b0110, 0);
        do_op(16'h0000, 16'h0000, OP_ADC, 16'h0001, 4'b0000, 0);
        do_op(16'h0003, 16'h0001, OP_SBC, 16'h0001, 4'b0010, 0);
        do_op(16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 4'b0011, 0);
        do_op(16'h00FF, 16'h0F01, OP_ADD, 16'h1000, 4'b0000, 3);
        do_op(16'h4000, 16'h4000, OP_ADD, 16'h8000, 4'b1001, 0);

        // set stored carry to 1, then abort an op with reset
        do_op(16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 4'b0110, 0);
        bus.in_valid = 1'b1;
        bus.a        = 16'hFFFF;
        bus.b        = 16'hFFFF;
        bus.sel      = OP_ADD;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_calc", {30'd0, state_dbg}, {30'd0, ST_CALC});
        rst_n = 1'b0;
        #2;
        chk("abort_async_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
        chk("abort_async_out_valid", {31'd0, bus.out_valid}, 32'd0);
        #3;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) bad++;
        end
        chk("abort_no_result", bad, 32'd0);
        do_op(16'h0000, 16'h0000, OP_ADC, 16'h0000, 4'b0100, 0);
        do_op(16'h0002, 16'h0003, OP_ADD, 16'h0005, 4'b0000, 0);

        cnt = 0;
        while (exp_q.size() != 0 && cnt < 50) begin
            @(posedge clk); #1; cnt++;
        end
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
